// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer of {instr, pc}
// pairs, flushed on redirect. Optional same-cycle pass-through when IQ_BYPASS_EN is defined.
module instr_queue #(
  parameter int BITS  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [BITS-1:0]          in_instr,
  input  logic [BITS-1:0]          in_pc,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [BITS-1:0]          out_instr,
  output logic [BITS-1:0]          out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [BITS-1:0] instr_mem [DEPTH];
  logic [BITS-1:0] pc_mem    [DEPTH];
  logic [DEPTH-1:0] entry_we;

  logic stored_full, stored_empty, active;
  logic bypass, through;
  logic push, pop, write_en, read_adv;

  assign stored_full  = (count_reg == CW'(DEPTH));
  assign stored_empty = (count_reg == '0);
  assign active       = rst && !flush;

`ifdef IQ_BYPASS_EN
  assign bypass = stored_empty && in_valid && active;
`else
  assign bypass = 1'b0;
`endif

  // Ready never looks at out_ready, keeping decode -> fetcher free of comb paths.
  assign in_ready  = active && !stored_full;
  assign out_valid = active && (!stored_empty || bypass);

  assign push    = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  // A bypassed instruction consumed in the same cycle never touches storage.
  assign through  = bypass && out_ready;
  assign write_en = push && !through;
  assign read_adv = pop && !stored_empty;

  always_comb begin
    out_instr = '0;
    out_pc    = '0;
    if (out_valid) begin
`ifdef IQ_BYPASS_EN
      if (stored_empty) begin
        out_instr = in_instr;
        out_pc    = in_pc;
      end else begin
        out_instr = instr_mem[rd_ptr_reg];
        out_pc    = pc_mem[rd_ptr_reg];
      end
`else
      out_instr = instr_mem[rd_ptr_reg];
      out_pc    = pc_mem[rd_ptr_reg];
`endif
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg + PW'(write_en);
    rd_ptr_next = rd_ptr_reg + PW'(read_adv);
    count_next  = count_reg;
    case ({write_en, read_adv})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = write_en && (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  // Storage is unreset; only entries between rd_ptr and wr_ptr are ever shown.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_we[i]) begin
        instr_mem[i] <= in_instr;
        pc_mem[i]    <= in_pc;
      end
    end
  end

  assign count = rst ? count_reg : '0;
  assign full  = rst && stored_full;
  assign empty = !rst || stored_empty;

endmodule
